// File: rtl/cmd_packet_scheduler_pkg.sv
// Shared types and sizes for the command-packet scheduler: bank and
// transmit state encodings plus the ping-pong buffer geometry.
package cmd_sched_pkg;

    localparam int NUM_REQ   = 2;
    localparam int NUM_BANKS = 2;
    localparam int BANK_W    = 1;
    localparam int BUF_DEPTH = 64;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int RAM_AW    = BANK_W + ADDR_W;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_SENDING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WAIT0 = 2'd1,
        TX_RUN   = 2'd2,
        TX_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/cmd_packet_scheduler_if.sv
// Bus between the scheduler and its clients: the frame builders (request,
// grant, shared byte-write bus) and packet_streamer (command read port).
interface cmd_packet_scheduler_if;
    import cmd_sched_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_commit;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_data;

    // Client side: frame builders and the streamer together.
    modport master (
        output req, wr_en, wr_addr, wr_data, wr_commit, cmd_addr,
        input  grant, cmd_ready, cmd_data
    );

    // Scheduler side.
    modport slave (
        input  req, wr_en, wr_addr, wr_data, wr_commit, cmd_addr,
        output grant, cmd_ready, cmd_data
    );

endinterface

// File: rtl/cmd_packet_scheduler_bank_ram.sv
// Two-bank frame buffer: simple dual-port RAM addressed by {bank, offset},
// one write port and one synchronous read port.
module cmd_bank_ram
    import cmd_sched_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [RAM_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_BANKS*BUF_DEPTH];

    // Byte write from the granted frame builder.
    // NOTE: the array has no reset: a resettable memory cannot map onto
    // block RAM, and stale frame bytes are harmless here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read for the streamer, one cycle of latency.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cmd_packet_scheduler.sv
// Round-robin arbiter for two frame builders feeding a ping-pong frame
// buffer, plus a transmit FSM that hands completed frames to the streamer
// in commit order, with a per-frame timeout.
module cmd_packet_scheduler
    import cmd_sched_pkg::*;
#(
    parameter int TX_TIMEOUT = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    cmd_packet_scheduler_if.slave bus,
    output logic [CNT_W-1:0]      sent_count,
    output logic [7:0]            drop_count
);

    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);

    bank_state_t          bank_state [NUM_BANKS];
    logic [NUM_BANKS-1:0] free_vec;
    logic [NUM_BANKS-1:0] full_vec;
    logic [NUM_BANKS-1:0] bank_tag;
    logic                 commit_seq;
    logic                 fill_bank;
    logic                 sending_bank;
    logic                 last_served;
    logic [NUM_REQ-1:0]   grant_q;
    logic [TMR_W-1:0]     timer;
    logic                 timer_hit;
    logic                 rd_valid;
    logic [DATA_W-1:0]    ram_q;

    tx_state_t tx_state;
    tx_state_t tx_next;
    logic      cmd_ready_c;
    logic      tx_start;
    logic      frame_sent;
    logic      frame_dropped;

    logic arb_fire;
    logic winner;
    logic free_bank;
    logic oldest_full;
    logic commit_fire;

    // Per-bank status flags.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            free_vec[i] = (bank_state[i] == BANK_FREE);
            full_vec[i] = (bank_state[i] == BANK_FULL);
        end
    end

    // Arbitration: the requester after the last-served one wins a tie, and
    // the lowest free bank is handed out.
    assign arb_fire    = (grant_q == '0) && (|free_vec) && (|bus.req);
    assign winner      = last_served ? ~bus.req[0] : bus.req[1];
    assign free_bank   = ~free_vec[0];
    assign commit_fire = bus.wr_commit && (grant_q != '0);

    // With two FULL banks, the one committed first carries the tag that
    // equals the current sequence bit (one commit has happened since).
    assign oldest_full = (&full_vec) ? (bank_tag[0] != commit_seq) : ~full_vec[0];
    assign timer_hit   = (timer == TMR_W'(TX_TIMEOUT - 1));

    // Transmit state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // Transmit next-state logic; completion beats a coincident timeout.
    // NOTE: tx_next gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (|full_vec) tx_next = TX_WAIT0;
            TX_WAIT0: begin
                if (timer_hit)                tx_next = TX_IDLE;
                else if (bus.cmd_addr == '0)  tx_next = TX_RUN;
            end
            TX_RUN: begin
                if (bus.cmd_addr == ADDR_W'(BUF_DEPTH - 1)) tx_next = TX_DONE;
                else if (timer_hit)                         tx_next = TX_IDLE;
            end
            TX_DONE:  tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // Transmit outputs and the bookkeeping events they trigger.
    always_comb begin
        cmd_ready_c   = 1'b0;
        tx_start      = 1'b0;
        frame_sent    = 1'b0;
        frame_dropped = 1'b0;
        unique case (tx_state)
            TX_IDLE:  tx_start = |full_vec;
            TX_WAIT0,
            TX_RUN: begin
                cmd_ready_c   = 1'b1;
                frame_dropped = (tx_next == TX_IDLE);
            end
            TX_DONE:  frame_sent = 1'b1;
            default:  ;
        endcase
    end

    // Bank bookkeeping, grant, timeout timer and counters.
    // NOTE: non-blocking assignments throughout, so every condition sees the
    // pre-edge state no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state[i] <= BANK_FREE;
            end
            bank_tag     <= '0;
            commit_seq   <= 1'b0;
            fill_bank    <= 1'b0;
            sending_bank <= 1'b0;
            last_served  <= 1'b1;
            grant_q      <= '0;
            timer        <= '0;
            rd_valid     <= 1'b0;
            sent_count   <= '0;
            drop_count   <= '0;
        end else begin
            if (arb_fire) begin
                grant_q               <= winner ? 2'b10 : 2'b01;
                last_served           <= winner;
                fill_bank             <= free_bank;
                bank_state[free_bank] <= BANK_FILLING;
            end
            if (commit_fire) begin
                grant_q               <= '0;
                bank_state[fill_bank] <= BANK_FULL;
                bank_tag[fill_bank]   <= commit_seq;
                commit_seq            <= ~commit_seq;
            end
            if (tx_start) begin
                sending_bank            <= oldest_full;
                bank_state[oldest_full] <= BANK_SENDING;
            end
            if (frame_sent || frame_dropped) begin
                bank_state[sending_bank] <= BANK_FREE;
            end
            if (frame_sent) begin
                sent_count <= sent_count + 1'b1;
            end
            if (frame_dropped && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            timer    <= (cmd_ready_c && (tx_next inside {TX_WAIT0, TX_RUN})) ? timer + 1'b1 : '0;
            rd_valid <= (tx_state != TX_IDLE);
        end
    end

    cmd_bank_ram u_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en && (grant_q != '0)),
        .wr_addr ({fill_bank, bus.wr_addr}),
        .wr_data (bus.wr_data),
        .rd_addr ({sending_bank, bus.cmd_addr}),
        .rd_data (ram_q)
    );

    assign bus.grant     = grant_q;
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.cmd_data  = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_cmd_packet_scheduler.sv
// Directed bench for cmd_packet_scheduler: single frame, contention, both
// banks busy, simultaneous commit/done, timeout with saturation, reset.
module tb_cmd_packet_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmd_packet_scheduler_if sched_bus ();
    cmd_packet_scheduler_if to_bus ();

    logic [15:0] sent_count, sent_count_to;
    logic [7:0]  drop_count, drop_count_to;

    cmd_packet_scheduler u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (sched_bus),
        .sent_count (sent_count),
        .drop_count (drop_count)
    );

    cmd_packet_scheduler #(.TX_TIMEOUT(16)) u_dut_to (
        .clk        (clk),
        .reset      (reset),
        .bus        (to_bus),
        .sent_count (sent_count_to),
        .drop_count (drop_count_to)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [7:0] base, input int i);
        logic [7:0] ii;
        ii = i[7:0];
        return base + ii * 8'h57;
    endfunction

    task automatic clear_inputs();
        sched_bus.req = '0; sched_bus.wr_en = 1'b0; sched_bus.wr_addr = '0;
        sched_bus.wr_data = '0; sched_bus.wr_commit = 1'b0; sched_bus.cmd_addr = 6'd63;
        to_bus.req = '0; to_bus.wr_en = 1'b0; to_bus.wr_addr = '0;
        to_bus.wr_data = '0; to_bus.wr_commit = 1'b0; to_bus.cmd_addr = 6'd63;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise req and wait (bounded) for a grant; returns the cycles taken.
    task automatic acquire(input logic [1:0] req_bits, input logic [1:0] exp_grant,
                           input string tag, input int budget, output int lat);
        lat = 0;
        sched_bus.req = req_bits;
        do begin
            @(negedge clk);
            lat++;
        end while (sched_bus.grant == 2'b00 && lat < budget);
        check(tag, sched_bus.grant, exp_grant);
    endtask

    task automatic write_bytes(input logic [7:0] base);
        for (int i = 0; i < 64; i++) begin
            sched_bus.wr_en   = 1'b1;
            sched_bus.wr_addr = i[5:0];
            sched_bus.wr_data = frame_byte(base, i);
            @(negedge clk);
        end
        sched_bus.wr_en = 1'b0;
    endtask

    task automatic commit();
        sched_bus.wr_commit = 1'b1;
        @(negedge clk);
        sched_bus.wr_commit = 1'b0;
    endtask

    // Streamer model: wait for cmd_ready, sweep 0..63, compare each byte one
    // cycle later, then expect cmd_ready low in the TX_DONE cycle.
    task automatic stream_frame(input logic [7:0] base, input string tag, input int budget);
        int c = 0;
        int nbad = 0;
        while (!sched_bus.cmd_ready && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!sched_bus.cmd_ready) begin
            check({tag, "_ready"}, 32'd0, 32'd1);
            return;
        end
        for (int a = 0; a < 64; a++) begin
            sched_bus.cmd_addr = a[5:0];
            @(negedge clk);
            if (sched_bus.cmd_data !== frame_byte(base, a)) nbad++;
        end
        check({tag, "_bytes_bad"}, nbad, 0);
        check({tag, "_release"}, sched_bus.cmd_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int high;
        logic [1:0] exp_grants [4];
        logic [7:0] bases [4];
        exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
        bases      = '{8'h10, 8'h20, 8'h35, 8'h4A};

        // Reset state.
        do_reset();
        check("rst_grant", sched_bus.grant, 2'b00);
        check("rst_ready", sched_bus.cmd_ready, 1'b0);
        check("rst_data", sched_bus.cmd_data, 8'h00);
        check("rst_sent", sent_count, 16'd0);
        check("rst_drop", drop_count, 8'd0);

        // 1. Single frame.
        acquire(2'b01, 2'b01, "t1_grant", 10, lat);
        sched_bus.req = '0;
        check("t1_grant_lat", lat, 1);
        write_bytes(8'hC8);
        commit();
        check("t1_grant_release", sched_bus.grant, 2'b00);
        check("t1_ready_early", sched_bus.cmd_ready, 1'b0);
        @(negedge clk);
        check("t1_ready_lat", sched_bus.cmd_ready, 1'b1);
        stream_frame(8'hC8, "t1", 5);
        @(negedge clk);
        check("t1_sent", sent_count, 16'd1);
        check("t1_ready_after", sched_bus.cmd_ready, 1'b0);

        // 2. Contention: both requesters held for four frames.
        do_reset();
        fork
            begin
                for (int f = 0; f < 4; f++) begin
                    acquire(2'b11, exp_grants[f], $sformatf("t2_grant%0d", f), 400, lat);
                    if (f == 3) sched_bus.req = '0;
                    write_bytes(bases[f]);
                    commit();
                end
            end
            begin
                for (int f = 0; f < 4; f++) begin
                    stream_frame(bases[f], $sformatf("t2_frame%0d", f), 400);
                end
            end
        join
        @(negedge clk);
        check("t2_sent", sent_count, 16'd4);

        // 3. Both banks busy: third request waits for the first TX_DONE.
        acquire(2'b01, 2'b01, "t3_grant_a", 10, lat);
        sched_bus.req = '0;
        write_bytes(8'h30);
        commit();
        acquire(2'b10, 2'b10, "t3_grant_b", 10, lat);
        sched_bus.req = '0;
        write_bytes(8'h40);
        commit();
        sched_bus.req = 2'b01;
        high = 0;
        repeat (10) begin
            @(negedge clk);
            if (sched_bus.grant != 2'b00) high++;
        end
        check("t3_wait_no_grant", high, 0);
        stream_frame(8'h30, "t3_a", 5);
        check("t3_done_grant", sched_bus.grant, 2'b00);
        repeat (2) @(negedge clk);
        check("t3_late_grant", sched_bus.grant, 2'b01);
        check("t3_next_ready", sched_bus.cmd_ready, 1'b1);
        sched_bus.req = '0;
        write_bytes(8'h50);
        commit();
        stream_frame(8'h40, "t3_b", 5);
        stream_frame(8'h50, "t3_c", 10);

        // 5. Commit on bank 1 in the TX_DONE cycle of bank 0.
        do_reset();
        acquire(2'b01, 2'b01, "t5_grant_a", 10, lat);
        sched_bus.req = '0;
        write_bytes(8'h60);
        commit();
        acquire(2'b10, 2'b10, "t5_grant_b", 10, lat);
        sched_bus.req = '0;
        write_bytes(8'h70);
        stream_frame(8'h60, "t5_a", 5);
        sched_bus.wr_commit = 1'b1;
        @(negedge clk);
        sched_bus.wr_commit = 1'b0;
        check("t5_sent_once", sent_count, 16'd1);
        check("t5_grant_release", sched_bus.grant, 2'b00);
        stream_frame(8'h70, "t5_b", 5);
        @(negedge clk);
        check("t5_sent_two", sent_count, 16'd2);

        // 4. Timeout on the 16-cycle instance; the streamer idles at 63.
        for (int f = 0; f < 260; f++) begin
            to_bus.req = 2'b01;
            @(negedge clk);
            if (f == 0) check("t4_grant", to_bus.grant, 2'b01);
            to_bus.req = '0;
            to_bus.wr_commit = 1'b1;
            @(negedge clk);
            to_bus.wr_commit = 1'b0;
            high = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (to_bus.cmd_ready) high++;
                else if (high > 0) break;
            end
            if (f == 0) begin
                check("t4_ready_cycles", high, 16);
                check("t4_ready_drop", to_bus.cmd_ready, 1'b0);
                check("t4_drop_one", drop_count_to, 8'd1);
            end
            if (f == 254) check("t4_drop_255", drop_count_to, 8'd255);
        end
        check("t4_drop_sat", drop_count_to, 8'd255);
        check("t4_sent_none", sent_count_to, 16'd0);

        // 6. Reset in TX_RUN at cmd_addr 20 with the other bank filling.
        acquire(2'b01, 2'b01, "t6_grant_a", 10, lat);
        sched_bus.req = '0;
        write_bytes(8'h80);
        commit();
        acquire(2'b10, 2'b10, "t6_grant_b", 10, lat);
        sched_bus.req = '0;
        lat = 0;
        while (!sched_bus.cmd_ready && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t6_ready", sched_bus.cmd_ready, 1'b1);
        for (int a = 0; a < 20; a++) begin
            sched_bus.cmd_addr = a[5:0];
            @(negedge clk);
        end
        sched_bus.cmd_addr = 6'd20;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_grant", sched_bus.grant, 2'b00);
        check("t6_ready_low", sched_bus.cmd_ready, 1'b0);
        check("t6_data", sched_bus.cmd_data, 8'h00);
        check("t6_sent", sent_count, 16'd0);
        check("t6_drop", drop_count, 8'd0);
        sched_bus.cmd_addr = 6'd63;
        sched_bus.req = 2'b11;
        @(negedge clk);
        check("t6_regrant", sched_bus.grant, 2'b01);
        sched_bus.req = '0;
        repeat (4) @(negedge clk);
        check("t6_no_frame", sched_bus.cmd_ready, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_packet_scheduler.md
# cmd_packet_scheduler

Shares the `packet_streamer` command-packet path between two frame generators: requester 0 is the ARP responder and requester 1 is the status reporter. Requesters receive a round-robin grant. The granted requester writes a 64-byte frame into a free bank of a two-bank (ping-pong) buffer. Completed frames are then presented to the streamer through the existing `cmd_ready`/`cmd_addr`/`cmd_data` port, in commit order. The block sits between the control-plane frame builders and `packet_streamer`, and replaces the static 64-byte command ROM.

## Interface
- `TX_TIMEOUT`, default 4096: cycles a frame may wait for `cmd_ready` to complete before it is dropped.
- `CNT_W`, default 16: width of `sent_count`.
- `clk`  in  1  single clock shared with the streamer.
- `reset`  in  1  synchronous, active-high.
- `req`  in  2  request, one bit per requester; held until granted.
- `grant`  out  2  one-hot or zero; held from grant until `wr_commit`.
- `wr_en`  in  1  byte write strobe on the shared write bus, driven by the granted requester only.
- `wr_addr`  in  6  byte offset within the frame.
- `wr_data`  in  8  byte value.
- `wr_commit`  in  1  one-cycle pulse: the frame is complete and the grant is released.
- `cmd_ready`  out  1  a frame is available to the streamer.
- `cmd_addr`  in  6  streamer read address.
- `cmd_data`  out  8  frame byte, registered.
- `sent_count`  out  `CNT_W`  frames completed; wraps.
- `drop_count`  out  8  frames dropped on timeout; saturates at 255.

## Operation
- **Bank states:** each bank is one of FREE, FILLING, FULL or SENDING.
- **After reset:**
  - Both banks are FREE.
  - `grant`, `cmd_ready` and both counters are 0.
  - The round-robin pointer is set so that requester 0 wins the first tie.
  - Buffer contents are not cleared.
- **Arbitration:**
  - Applies only when `grant` is 0 and at least one bank is FREE.
  - Among the asserted `req` bits, the requester after the last-served one wins.
  - The chosen FREE bank is the lowest-index FREE bank; it becomes FILLING.
  - The pointer updates on grant.
- **Writes:**
  - `wr_en` with `grant` nonzero writes `wr_data` to FILLING[`wr_addr`].
  - `wr_en` with `grant` zero is ignored.
  - Unwritten bytes keep their stale content.
- **Commit:**
  - `wr_commit` with `grant` nonzero: the FILLING bank becomes FULL, `grant` goes to 0 the next cycle, and the bank records its commit order.
  - `wr_commit` with `grant` zero is ignored.
- **Transmit FSM states:**
  - TX_IDLE: when any bank is FULL, the oldest FULL bank becomes SENDING and the FSM moves to TX_WAIT0.
  - TX_WAIT0: `cmd_ready`=1; wait for `cmd_addr`==0, then move to TX_RUN.
  - TX_RUN: `cmd_ready`=1; on `cmd_addr`==63, move to TX_DONE.
  - TX_DONE: the bank becomes FREE, `sent_count` increments, and the FSM returns to TX_IDLE.
- **Timeout:**
  - A counter runs in TX_WAIT0 and TX_RUN.
  - When it reaches `TX_TIMEOUT`, the bank becomes FREE, `drop_count` increments (saturating), and the FSM returns to TX_IDLE.
- **`cmd_data`:** the SENDING bank's byte at `cmd_addr`, registered. It is 0x00 when no bank is SENDING.
- **Simultaneous events:**
  - A commit and a TX_DONE/timeout in the same cycle both take effect.
  - A bank freed in cycle N is grantable in cycle N+1.
  - A request that arrives while both banks are non-FREE waits, with no loss.
- **Reset mid-operation:** forces all reset values, discards all frames in flight, and does not count them as dropped.

## Timing
- **Grant latency:** `req` sampled high in cycle N (bank free, no grant active) → `grant` high in cycle N+1.
- **Write latency:** 0 cycles; a byte written in cycle N is readable from cycle N+1.
- **Commit to `cmd_ready`:** commit in cycle N with the transmit FSM idle → bank FULL in N+1 → `cmd_ready` high in N+2.
- **Read latency:** `cmd_data` is valid one cycle after `cmd_addr`, matching the previous ROM.
- **Release after completion:** `cmd_ready` drops in the cycle after `cmd_addr`==63 is seen in TX_RUN (the TX_DONE cycle). The next FULL bank raises `cmd_ready` 2 cycles later.
- **Back-to-back frames:** `cmd_ready` has at least a 1-cycle low gap between frames.
- **Streamer idle address:** if the streamer idles at `cmd_addr`==63 before starting, TX_WAIT0 ignores it.

## Structure
- Package `cmd_sched_pkg` holds:
  - the bank-state encoding (FREE/FILLING/FULL/SENDING);
  - the transmit-state encoding;
  - `NUM_REQ`=2, `BUF_DEPTH`=64, `ADDR_W`=6.
- One sub-module, `cmd_bank_ram`: a 2×64×8 simple dual-port RAM with a synchronous read port. Its address is {bank, offset} and it infers block RAM.
- Arbitration, bank bookkeeping, the transmit FSM and the counters stay in the top module.

## Test plan
1. **Single frame:** after reset, `req`=01; write bytes 0..63 = 0xC8,0x1F,…; then `wr_commit`.
   - Expect `grant`=01 one cycle after `req`.
   - Expect `cmd_ready` two cycles after commit.
   - A streamer model sweeps 0..63 and reads identical bytes with 1-cycle latency.
   - Afterwards `sent_count`=1 and `cmd_ready` is 0.
2. **Contention:** `req`=11 held for 4 frames.
   - Expected grant order: 01, 10, 01, 10.
   - Frames are transmitted in commit order.
3. **Both banks full:** a third request waits with `grant`=0 until the first TX_DONE, then is granted within 1 cycle.
4. **Timeout:** `TX_TIMEOUT`=16 and the streamer never reads.
   - `cmd_ready` drops after 16 cycles and `drop_count`=1.
   - 260 timeouts → `drop_count` saturates at 255.
5. **Simultaneous events:** commit on bank 1 in the same cycle as TX_DONE on bank 0 → bank 1 is sent next and `sent_count` increments once.
6. **Reset mid-frame:** assert `reset` in TX_RUN at `cmd_addr`=20.
   - The next cycle shows all outputs at 0 and the banks FREE.
   - `drop_count` is unchanged at 0.
